dmem_lsu: RTL and testbench

Load/store unit between the pipelined RV32I core's MEM stage and a synchronous data SRAM with configurable read latency. It accepts one access per MEM-stage request and converts byte/half/word stores into byte-lane write enables with replicated data. Load data is extracted and sign/zero-extended. The unit holds the pipeline via `stall` until the access completes and flags misaligned accesses without touching memory.

---
 rtl/dmem_lsu_if.sv | 34 +++
 rtl/dmem_lsu.sv | 182 ++++++++++++++++++
 tb/tb_dmem_lsu.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Core/SRAM-side signal bundle for the data load/store unit.
// The slave view belongs to the LSU; the master view to its environment.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_dmtype,
    input  req_addr, req_wdata, mem_rdata,
    output stall, rsp_valid, rsp_rdata,
    output misalign, mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_dmtype,
    output req_addr, req_wdata, mem_rdata,
    input  stall, rsp_valid, rsp_rdata,
    input  misalign, mem_en, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: lane steering, load extension,
// misalignment rejection and pipeline stall for a latency-N SRAM.
module dmem_lsu #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input logic       clk,
  input logic       reset,
  dmem_lsu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       type_q, type_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             req_mis;
  logic [3:0]       lane_we;
  logic [31:0]      lane_wd;
  logic [31:0]      ld_sh;
  logic [31:0]      ld_ext;

  function automatic logic is_byte(
    input logic [2:0] t
  );
    return (t == 3'b011) || (t == 3'b100);
  endfunction

  function automatic logic is_half(
    input logic [2:0] t
  );
    return (t == 3'b001) || (t == 3'b010);
  endfunction

  function automatic logic is_sgn(
    input logic [2:0] t
  );
    return (t == 3'b011) || (t == 3'b001);
  endfunction

  function automatic logic is_word(
    input logic [2:0] t
  );
    return !is_byte(t) && !is_half(t);
  endfunction

  // Checked on the live request so a bad access never reaches ISSUE.
  always_comb begin
    req_mis = 1'b0;
    if (is_word(bus.req_dmtype))
      req_mis = bus.req_addr[1:0] != 2'b00;
    else if (is_half(bus.req_dmtype))
      req_mis = bus.req_addr[0];
  end

  always_comb begin
    lane_we = 4'b1111;
    lane_wd = wdata_q;
    unique case (1'b1)
      is_byte(type_q): begin
        lane_we = 4'b0001 << addr_q[1:0];
        lane_wd = {4{wdata_q[7:0]}};
      end
      is_half(type_q): begin
        lane_we = 4'b0011 << {addr_q[1], 1'b0};
        lane_wd = {2{wdata_q[15:0]}};
      end
      is_word(type_q): begin
        lane_we = 4'b1111;
        lane_wd = wdata_q;
      end
    endcase
  end

  always_comb begin
    ld_sh  = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    ld_ext = ld_sh;
    unique case (1'b1)
      is_byte(type_q):
        ld_ext = {{24{is_sgn(type_q) & ld_sh[7]}},
                  ld_sh[7:0]};
      is_half(type_q):
        ld_ext = {{16{is_sgn(type_q) & ld_sh[15]}},
                  ld_sh[15:0]};
      is_word(type_q):
        ld_ext = ld_sh;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          type_d  = bus.req_dmtype;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = req_mis;
          rdata_d = '0;
          state_d = req_mis ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (cnt_inc == LAT) begin
          rdata_d = ld_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  wire is_done  = state_q == DONE;
  wire is_issue = state_q == ISSUE;

  assign bus.stall = bus.req_valid & ~is_done & reset;
  assign bus.rsp_valid = is_done;
  assign bus.misalign  = is_done & err_q;
  assign bus.rsp_rdata = is_done ? rdata_q : '0;
  assign bus.mem_en    = is_issue;
  assign bus.mem_we    = (is_issue & we_q) ? lane_we : 4'b0000;
  assign bus.mem_addr  = addr_q[31:2];
  assign bus.mem_wdata = lane_wd;

endmodule

// File: tb/tb_dmem_lsu.sv
// Random and directed bench for dmem_lsu at read latencies 1 and 3,
// checked against a byte-addressed memory model.
module tb_dmem_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic        rv[2];
  logic        rwe[2];
  logic [2:0]  rty[2];
  logic [31:0] rad[2];
  logic [31:0] rwd[2];
  logic        st[2];
  logic        rsv[2];
  logic        mis_o[2];
  logic        men[2];
  logic [3:0]  mwe[2];
  logic [29:0] mad[2];
  logic [31:0] mwd[2];
  logic [31:0] rrd[2];

  dmem_lsu_if ifc0();
  dmem_lsu_if ifc1();

  dmem_lsu #(.MEM_LAT(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .reset(reset), .bus(ifc0.slave)
  );
  dmem_lsu #(.MEM_LAT(3), .CNT_W(4)) u_lat3 (
    .clk(clk), .reset(reset), .bus(ifc1.slave)
  );

  assign ifc0.req_valid  = rv[0];
  assign ifc0.req_we     = rwe[0];
  assign ifc0.req_dmtype = rty[0];
  assign ifc0.req_addr   = rad[0];
  assign ifc0.req_wdata  = rwd[0];
  assign ifc1.req_valid  = rv[1];
  assign ifc1.req_we     = rwe[1];
  assign ifc1.req_dmtype = rty[1];
  assign ifc1.req_addr   = rad[1];
  assign ifc1.req_wdata  = rwd[1];

  assign st[0]    = ifc0.stall;
  assign rsv[0]   = ifc0.rsp_valid;
  assign mis_o[0] = ifc0.misalign;
  assign men[0]   = ifc0.mem_en;
  assign mwe[0]   = ifc0.mem_we;
  assign mad[0]   = ifc0.mem_addr;
  assign mwd[0]   = ifc0.mem_wdata;
  assign rrd[0]   = ifc0.rsp_rdata;
  assign st[1]    = ifc1.stall;
  assign rsv[1]   = ifc1.rsp_valid;
  assign mis_o[1] = ifc1.misalign;
  assign men[1]   = ifc1.mem_en;
  assign mwe[1]   = ifc1.mem_we;
  assign mad[1]   = ifc1.mem_addr;
  assign mwd[1]   = ifc1.mem_wdata;
  assign rrd[1]   = ifc1.rsp_rdata;

  // SRAM models; read data is junk except in its valid cycle
  logic [31:0] smem[2][64];
  logic [31:0] pd[2][4];
  logic        pv[2][4];
  logic        poke = 1'b0;
  int          poke_u = 0;
  logic [5:0]  poke_a = '0;
  logic [31:0] poke_d = '0;

  always @(posedge clk) begin
    if (poke) smem[poke_u][poke_a] <= poke_d;
    for (int u = 0; u < 2; u++) begin
      if (men[u])
        for (int j = 0; j < 4; j++)
          if (mwe[u][j])
            smem[u][mad[u][5:0]][8*j +: 8] <= mwd[u][8*j +: 8];
      pv[u][0] <= men[u] && (mwe[u] == 4'b0000);
      pd[u][0] <= smem[u][mad[u][5:0]];
      for (int i = 1; i < 4; i++) begin
        pv[u][i] <= pv[u][i-1];
        pd[u][i] <= pd[u][i-1];
      end
    end
  end

  assign ifc0.mem_rdata = pv[0][0] ? pd[0][0] : 32'hBAD0BAD0;
  assign ifc1.mem_rdata = pv[1][2] ? pd[1][2] : 32'hBAD0BAD0;

  // reference: flat byte memory, address bits [7:0]
  logic [7:0] rmem[2][256];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int acc_n(input logic [2:0] t);
    if (t == 3'b011 || t == 3'b100) return 1;
    if (t == 3'b001 || t == 3'b010) return 2;
    return 4;
  endfunction

  task automatic poke_word(input int u,
                           input logic [7:0] a,
                           input logic [31:0] d);
    poke   = 1'b1;
    poke_u = u;
    poke_a = a[7:2];
    poke_d = d;
    @(posedge clk);
    #1 poke = 1'b0;
    for (int j = 0; j < 4; j++)
      rmem[u][{a[7:2], 2'(j)}] = d[8*j +: 8];
  endtask

  task automatic chk_zero(input int u, input string tag);
    chk(tag, 32'({st[u], rsv[u], mis_o[u], men[u], mwe[u]}), 0);
    chk(tag, 32'(mad[u]), 0);
    chk(tag, mwd[u], 0);
    chk(tag, rrd[u], 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the response.
  task automatic do_txn(input int u,
                        input logic we,
                        input logic [2:0] ty,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input int drop_at,
                        output logic [31:0] got);
    int n, lat, done_k;
    logic mis;
    logic [3:0] ewe;
    logic [31:0] ewd, eld;
    logic [7:0] b;
    n   = acc_n(ty);
    lat = (u == 0) ? 1 : 3;
    mis = (n == 4 && addr[1:0] != 2'b00) ||
          (n == 2 && addr[0]);
    done_k = mis ? 1 : (we ? 2 : 2 + lat);
    ewe = 4'b0000;
    eld = 32'h0;
    for (int j = 0; j < n; j++) begin
      ewe[(int'(addr[1:0]) + j) % 4] = 1'b1;
      b = rmem[u][addr[7:0] + 8'(j)];
      eld = eld | (32'(b) << (8 * j));
    end
    if (n == 1 && ty == 3'b011 && eld[7])
      eld = eld | 32'hFFFFFF00;
    if (n == 2 && ty == 3'b001 && eld[15])
      eld = eld | 32'hFFFF0000;
    if (n == 1) ewd = {4{wd[7:0]}};
    else if (n == 2) ewd = {2{wd[15:0]}};
    else ewd = wd;
    got = 32'h0;
    rv[u] = 1'b1; rwe[u] = we; rty[u] = ty;
    rad[u] = addr; rwd[u] = wd;
    for (int k = 0; k <= done_k; k++) begin
      if (drop_at > 0 && k == drop_at) rv[u] = 1'b0;
      @(negedge clk);
      chk("stall", 32'(st[u]), 32'(rv[u] && k < done_k));
      chk("mem_en", 32'(men[u]), 32'(!mis && k == 1));
      chk("rsp_valid", 32'(rsv[u]), 32'(k == done_k));
      chk("mem_we", 32'(mwe[u]),
          32'((!mis && we && k == 1) ? ewe : 4'b0000));
      if (k == 1 && !mis) begin
        chk("mem_addr", 32'(mad[u]), 32'(addr[31:2]));
        if (we) chk("mem_wdata", mwd[u], ewd);
      end
      if (k == done_k) begin
        chk("misalign", 32'(mis_o[u]), 32'(mis));
        chk("rsp_rdata", rrd[u], (mis || we) ? 32'h0 : eld);
        got = rrd[u];
      end
      @(posedge clk);
      #1;
    end
    rv[u] = 1'b0;
    if (we && !mis)
      for (int j = 0; j < n; j++)
        rmem[u][addr[7:0] + 8'(j)] = wd[8*j +: 8];
  endtask

  logic [31:0] got;

  initial begin
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rv[u] = 1'b0; rwe[u] = 1'b0; rty[u] = '0;
      rad[u] = '0;  rwd[u] = '0;
    end
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 64; w++)
        poke_word(u, 8'(w * 4), $urandom);
    @(negedge clk);
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    @(posedge clk);
    #1 reset = 1'b1;

    do_txn(0, 1, 3'b000, 32'h100, 32'hDEADBEEF, 0, got);
    do_txn(0, 0, 3'b000, 32'h100, 32'h0, 0, got);
    chk("ld_word", got, 32'hDEADBEEF);
    do_txn(0, 1, 3'b011, 32'h103, 32'h000000A5, 0, got);
    do_txn(0, 0, 3'b000, 32'h100, 32'h0, 0, got);
    chk("st_byte3", got, 32'hA5ADBEEF);

    poke_word(0, 8'h00, 32'h80F17F23);
    do_txn(0, 0, 3'b011, 32'h102, 32'h0, 0, got);
    chk("lb", got, 32'hFFFFFFF1);
    do_txn(0, 0, 3'b100, 32'h102, 32'h0, 0, got);
    chk("lbu", got, 32'h000000F1);
    do_txn(0, 0, 3'b001, 32'h102, 32'h0, 0, got);
    chk("lh", got, 32'hFFFF80F1);
    do_txn(0, 0, 3'b010, 32'h100, 32'h0, 0, got);
    chk("lhu", got, 32'h00007F23);

    do_txn(0, 0, 3'b000, 32'h102, 32'h0, 0, got);
    do_txn(0, 1, 3'b001, 32'h101, 32'h1234, 0, got);
    do_txn(0, 0, 3'b000, 32'h100, 32'h0, 0, got);
    chk("mis_nowrite", got, 32'h80F17F23);

    poke_word(1, 8'h10, 32'h12345678);
    do_txn(1, 0, 3'b000, 32'h110, 32'h0, 2, got);
    chk("lat3_drop", got, 32'h12345678);
    do_txn(1, 0, 3'b001, 32'h112, 32'h0, 0, got);
    chk("lat3_lh", got, 32'h00001234);

    rv[1] = 1'b1; rwe[1] = 1'b0;
    rty[1] = 3'b000; rad[1] = 32'h110;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_zero(1, "rst_mid");
    rv[1] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    do_txn(1, 1, 3'b000, 32'h114, 32'hCAFEF00D, 0, got);
    do_txn(1, 0, 3'b000, 32'h114, 32'h0, 0, got);
    chk("post_rst", got, 32'hCAFEF00D);

    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 120; i++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("idle", 32'({st[u], rsv[u], men[u]}), 0);
          @(posedge clk); #1;
        end
        do_txn(u, 1'($urandom), 3'($urandom_range(0, 7)),
               {24'h000001, 8'($urandom)}, $urandom,
               ($urandom_range(0, 3) == 0) ? 1 : 0, got);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
